booth_mult_seq: RTL and testbench

- Sequential radix-2 Booth multiplier core.
- Consumes the multiplicand and multiplier words held in the 16-bit parallel load registers.
- Produces a signed 2*WIDTH product after WIDTH add/shift iterations.
- Sits directly downstream of the operand registers and upstream of the result register/bus.
- Runs a start/busy/done handshake with the system controller.

---
 rtl/booth_pkg.sv | 31 +++
 rtl/booth_mult_seq_if.sv | 25 ++
 rtl/booth_addsub.sv | 22 ++
 rtl/booth_mult_seq.sv | 98 +++++++++
 tb/tb_booth_mult_seq.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier:
// FSM state encoding, Booth recoding operations and default widths.
package booth_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10
    } op_t;

    // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], Q[-1]}.
    function automatic op_t booth_decode(input logic q0, input logic qm1);
        op_t op;
        case ({q0, qm1})
            2'b10:   op = OP_SUB;
            2'b01:   op = OP_ADD;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Start/busy/done handshake plus operand and product buses of the Booth multiplier.
interface booth_mult_seq_if
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic                      start;
    logic signed [WIDTH-1:0]   m_in;
    logic signed [WIDTH-1:0]   q_in;
    logic                      busy;
    logic                      done;
    logic signed [2*WIDTH-1:0] product;

    modport master (
        output start, m_in, q_in,
        input  busy, done, product
    );

    modport slave (
        input  start, m_in, q_in,
        output busy, done, product
    );

endinterface

// File: rtl/booth_addsub.sv
// Combinational WIDTH+1-bit accumulator update for one Booth iteration.
module booth_addsub
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  op_t                  op_i,
    input  logic signed [WIDTH:0] a_i,
    input  logic signed [WIDTH:0] m_i,
    output logic signed [WIDTH:0] sum_o
);

    // One guard bit on A and M keeps A - M exact even for M = -2**(WIDTH-1).
    always_comb begin
        case (op_i)
            OP_ADD:  sum_o = a_i + m_i;
            OP_SUB:  sum_o = a_i - m_i;
            default: sum_o = a_i;
        endcase
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one add/shift iteration per cycle,
// WIDTH iterations per operation, start/busy/done handshake.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    booth_mult_seq_if.slave  bus
);

    state_t                    state_q, state_d;
    logic signed [WIDTH:0]     a_q, a_d;
    logic        [WIDTH-1:0]   q_q, q_d;
    logic                      qm1_q, qm1_d;
    logic signed [WIDTH:0]     m_q, m_d;
    logic        [CNT_W-1:0]   cnt_q, cnt_d;
    logic signed [2*WIDTH-1:0] product_q, product_d;

    op_t                       op;
    logic signed [WIDTH:0]     sum;

    assign op = booth_decode(q_q[0], qm1_q);

    booth_addsub #(.WIDTH(WIDTH)) u_addsub (
        .op_i  (op),
        .a_i   (a_q),
        .m_i   (m_q),
        .sum_o (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    m_d     = {bus.m_in[WIDTH-1], bus.m_in};
                    q_d     = bus.q_in;
                    a_d     = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = RUN;
                end
            end
            RUN: begin
                // Arithmetic right shift of {A', Q, Qm1}, replicating the A sign bit.
                a_d   = {sum[WIDTH], sum[WIDTH:1]};
                q_d   = {sum[0], q_q[WIDTH-1:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = DONE;
                    product_d = {a_d[WIDTH-1:0], q_d};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.product = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq: expected products queued at start, checked on done.
module tb_booth_mult_seq;
    import booth_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    booth_mult_seq_if #(.WIDTH(W)) bus ();

    booth_mult_seq #(.WIDTH(W), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_prod = '0;
    logic [31:0] mon_exp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb_q.size() == 0) begin
                check("extra_done", {63'd0, bus.done}, 64'd0);
            end else begin
                mon_exp = sb_q.pop_front();
                check("product", {32'd0, bus.product}, {32'd0, mon_exp});
            end
        end
    end

    // Called just after a rising edge with the DUT in IDLE; returns just after
    // the rising edge that ends the DONE cycle (the first IDLE cycle).
    task automatic do_op(input logic [15:0] m, input logic [15:0] q,
                         input logic [31:0] exp, input bit glitch);
        int lat;
        int busy_n;
        bit seen;
        bus.m_in  = m;
        bus.q_in  = q;
        bus.start = 1'b1;
        sb_q.push_back(exp);
        @(negedge clk);
        check("idle_busy", {63'd0, bus.busy}, 64'd0);
        check("idle_done", {63'd0, bus.done}, 64'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0; busy_n = 0; seen = 1'b0;
        for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
            if (glitch && (cyc == 3 || cyc == 10)) begin
                bus.start = 1'b1;
                bus.m_in  = 16'($urandom);
                bus.q_in  = 16'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (bus.busy) busy_n++;
            if (cyc == 8) check("prod_hold", {32'd0, bus.product}, {32'd0, last_prod});
            if (bus.done) begin
                seen = 1'b1;
                lat  = cyc;
            end else begin
                @(posedge clk); #1;
            end
        end
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("done_seen", {63'd0, seen}, 64'd1);
        if (!seen) sb_q.delete();
        check("latency", 64'(lat), 64'd17);
        check("busy_cycles", 64'(busy_n), 64'd17);
        last_prod = exp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic signed [15:0] mr, qr;
        logic signed [31:0] er;
        int dn;
        bus.start = 1'b0;
        bus.m_in  = '0;
        bus.q_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_product", {32'd0, bus.product}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(16'd3, 16'd5, 32'h0000000F, 1'b0);
        do_op(16'hFFFD, 16'd5, 32'hFFFFFFF1, 1'b0);
        do_op(16'd7, 16'hFFFF, 32'hFFFFFFF9, 1'b0);
        do_op(16'h8000, 16'h8000, 32'h40000000, 1'b0);
        do_op(16'h8000, 16'd1, 32'hFFFF8000, 1'b0);
        do_op(16'h7FFF, 16'h8000, 32'hC0008000, 1'b0);
        do_op(16'd100, 16'd200, 32'h00004E20, 1'b1);

        // Reset in the middle of a run.
        bus.m_in  = 16'd1234;
        bus.q_in  = 16'd5;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("abort_busy_pre", {63'd0, bus.busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        check("abort_done", {63'd0, bus.done}, 64'd0);
        check("abort_product", {32'd0, bus.product}, 64'd0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        dn = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        check("abort_no_done", 64'(dn), 64'd0);
        check("abort_idle", {63'd0, bus.busy}, 64'd0);
        last_prod = '0;
        @(posedge clk); #1;
        do_op(16'd0, 16'hFFFF, 32'h00000000, 1'b0);

        // Back-to-back: second start in the first IDLE cycle.
        do_op(16'd0, 16'h1234, 32'h00000000, 1'b0);
        do_op(16'hFFFF, 16'hFFFF, 32'h00000001, 1'b0);

        for (int i = 0; i < 4; i++) begin
            mr = 16'($urandom);
            qr = 16'($urandom);
            er = mr * qr;
            do_op(mr, qr, er, 1'b0);
        end

        @(negedge clk);
        check("final_busy", {63'd0, bus.busy}, 64'd0);
        check("final_done", {63'd0, bus.done}, 64'd0);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
